// File: rtl/cache_tag_array.sv
// cache_tag_array
//   N-way set-associative tag/state store for the L2 cache model. Each line
//   holds a tag, a MESI state and a true-LRU rank (0 = MRU). The store
//   accepts one request per cycle: READ, WRITE, FILL and SNOOP. It answers
//   with a way number that the controller uses to address the line-data array.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake; accepted on a posedge when both are high
//   req_op            00 READ, 01 WRITE, 10 FILL, 11 SNOOP
//   req_index/tag     set select and address tag
//   req_mesi          FILL install state / SNOOP new state
//   resp_valid        one-cycle pulse in the cycle after acceptance
//   resp_hit/way      hit flag; hit way, or victim/filled way on a miss
//   resp_mesi         prior state of the hit line (0 on a miss)
//   resp_victim_*     prior contents of the selected victim (0 on a hit)
//   init_done         clear sweep finished; the array is serving requests
module cache_tag_array #(
  parameter int  INDEX_BITS = 14,
  parameter int  TAG_BITS   = 12,
  parameter int  WAYS       = 8,
  localparam int WAY_BITS   = $clog2(WAYS),
  localparam int SETS       = 2 ** INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [INDEX_BITS-1:0] req_index,
  input  logic [TAG_BITS-1:0]   req_tag,
  input  logic [1:0]            req_mesi,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [WAY_BITS-1:0]   resp_way,
  output logic [1:0]            resp_mesi,
  output logic [TAG_BITS-1:0]   resp_victim_tag,
  output logic [1:0]            resp_victim_mesi,
  output logic                  init_done
);

  localparam logic [1:0] MESI_I = 2'b00;
  localparam logic [1:0] MESI_M = 2'b11;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_FILL  = 2'b10,
    OP_SNOOP = 2'b11
  } op_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [INDEX_BITS-1:0] r_sweep;

  logic [TAG_BITS-1:0]   r_tag  [SETS][WAYS];
  logic [1:0]            r_mesi [SETS][WAYS];
  logic [WAY_BITS-1:0]   r_lru  [SETS][WAYS];

  logic                  w_accept;
  op_e                   w_op;
  logic                  w_hit;
  logic [WAY_BITS-1:0]   w_hit_way;
  logic                  w_inv_found;
  logic [WAY_BITS-1:0]   w_inv_way;
  logic [WAY_BITS-1:0]   w_old_way;
  logic [WAY_BITS-1:0]   w_vic_way;
  logic                  w_touch;
  logic [WAY_BITS-1:0]   w_touch_way;
  logic [WAY_BITS-1:0]   w_touch_rank;
  logic [TAG_BITS-1:0]   w_new_tag  [WAYS];
  logic [1:0]            w_new_mesi [WAYS];
  logic [WAY_BITS-1:0]   w_new_lru  [WAYS];

  assign req_ready = (r_state == ST_RUN);
  assign init_done = (r_state == ST_RUN);
  assign w_accept  = req_valid & req_ready;
  assign w_op      = op_e'(req_op);

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_sweep <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) r_sweep <= r_sweep + INDEX_BITS'(1);
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_sweep == '1) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
    endcase
  end

  // ------------------------------------------------------ lookup / victim
  // Descending scan so the lowest-index match wins for the invalid search.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    w_old_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_mesi[req_index][w] == MESI_I) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_BITS'(w);
      end
      if (r_lru[req_index][w] == WAY_BITS'(WAYS - 1)) w_old_way = WAY_BITS'(w);
      if (r_mesi[req_index][w] != MESI_I && r_tag[req_index][w] == req_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_BITS'(w);
      end
    end
  end

  assign w_vic_way = w_inv_found ? w_inv_way : w_old_way;

  // ----------------------------------------------------- next set contents
  always_comb begin
    w_touch     = 1'b0;
    w_touch_way = w_hit ? w_hit_way : w_vic_way;
    for (int w = 0; w < WAYS; w++) begin
      w_new_tag[w]  = r_tag[req_index][w];
      w_new_mesi[w] = r_mesi[req_index][w];
      w_new_lru[w]  = r_lru[req_index][w];
    end
    case (w_op)
      OP_READ: w_touch = w_hit;
      OP_WRITE: begin
        w_touch = w_hit;
        if (w_hit) w_new_mesi[w_hit_way] = MESI_M;
      end
      OP_FILL: begin
        w_touch = 1'b1;
        if (w_hit) begin
          w_new_mesi[w_hit_way] = req_mesi;
        end else begin
          w_new_tag[w_vic_way]  = req_tag;
          w_new_mesi[w_vic_way] = req_mesi;
        end
      end
      OP_SNOOP: if (w_hit) w_new_mesi[w_hit_way] = req_mesi;
    endcase
    // Ranks above the touched way's old rank are untouched, so the set
    // stays a permutation of 0..WAYS-1.
    w_touch_rank = r_lru[req_index][w_touch_way];
    if (w_touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_BITS'(w) == w_touch_way)
          w_new_lru[w] = '0;
        else if (r_lru[req_index][w] < w_touch_rank)
          w_new_lru[w] = r_lru[req_index][w] + WAY_BITS'(1);
      end
    end
  end

  // -------------------------------------------------------------- storage
  // NOTE: the storage arrays have no reset; the INIT sweep clears one set
  // per cycle instead, which keeps them mappable onto RAM.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      for (int w = 0; w < WAYS; w++) begin
        r_tag[r_sweep][w]  <= '0;
        r_mesi[r_sweep][w] <= MESI_I;
        r_lru[r_sweep][w]  <= WAY_BITS'(w);
      end
    end else if (w_accept) begin
      for (int w = 0; w < WAYS; w++) begin
        r_tag[req_index][w]  <= w_new_tag[w];
        r_mesi[req_index][w] <= w_new_mesi[w];
        r_lru[req_index][w]  <= w_new_lru[w];
      end
    end
  end

  // ------------------------------------------------------------- response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid       <= 1'b0;
      resp_hit         <= 1'b0;
      resp_way         <= '0;
      resp_mesi        <= '0;
      resp_victim_tag  <= '0;
      resp_victim_mesi <= '0;
    end else begin
      resp_valid <= w_accept;
      if (w_accept) begin
        resp_hit         <= w_hit;
        resp_way         <= w_hit ? w_hit_way : w_vic_way;
        resp_mesi        <= w_hit ? r_mesi[req_index][w_hit_way] : 2'b00;
        resp_victim_tag  <= w_hit ? '0 : r_tag[req_index][w_vic_way];
        resp_victim_mesi <= w_hit ? 2'b00 : r_mesi[req_index][w_vic_way];
      end
    end
  end

endmodule

// File: tb/tb_cache_tag_array.sv
// Self-checking bench for cache_tag_array (INDEX_BITS=3, TAG_BITS=8, WAYS=4).
// Directed table of vectors, randomized traffic against a recency-list
// reference model, and an asynchronous reset in the middle of traffic.
module tb_cache_tag_array;

  localparam int IB   = 3;
  localparam int TB   = 8;
  localparam int NW   = 4;
  localparam int NS   = 2 ** IB;
  localparam int WB   = 2;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [IB-1:0] req_index;
  logic [TB-1:0] req_tag;
  logic [1:0]    req_mesi;
  logic          resp_valid;
  logic          resp_hit;
  logic [WB-1:0] resp_way;
  logic [1:0]    resp_mesi;
  logic [TB-1:0] resp_victim_tag;
  logic [1:0]    resp_victim_mesi;
  logic          init_done;

  cache_tag_array #(.INDEX_BITS(IB), .TAG_BITS(TB), .WAYS(NW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_index        (req_index),
    .req_tag          (req_tag),
    .req_mesi         (req_mesi),
    .resp_valid       (resp_valid),
    .resp_hit         (resp_hit),
    .resp_way         (resp_way),
    .resp_mesi        (resp_mesi),
    .resp_victim_tag  (resp_victim_tag),
    .resp_victim_mesi (resp_victim_mesi),
    .init_done        (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit hit;
    int way;
    int mesi;
    int vtag;
    int vmesi;
  } exp_t;

  typedef struct {
    int   op;
    int   idx;
    int   tag;
    int   mesi;
    exp_t e;
  } vec_t;

  vec_t vecs[16];

  // Reference model: tag/state per line and, per set, an ordered recency
  // list of way numbers (position 0 = most recently used).
  int m_tag   [NS][NW];
  int m_mesi  [NS][NW];
  int m_order [NS][NW];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        m_tag[s][w]   = 0;
        m_mesi[s][w]  = 0;
        m_order[s][w] = w;
      end
  endtask

  task automatic model_touch(input int s, input int w);
    int p;
    p = 0;
    for (int k = 0; k < NW; k++) if (m_order[s][k] == w) p = k;
    for (int k = p; k > 0; k--) m_order[s][k] = m_order[s][k-1];
    m_order[s][0] = w;
  endtask

  task automatic model_step(input int op, input int s, input int tg, input int ms, output exp_t e);
    int hw;
    int vic;
    hw  = -1;
    vic = -1;
    for (int w = 0; w < NW; w++)
      if (m_mesi[s][w] != 0 && m_tag[s][w] == tg) hw = w;
    for (int w = 0; w < NW && vic < 0; w++)
      if (m_mesi[s][w] == 0) vic = w;
    if (vic < 0) vic = m_order[s][NW-1];
    e.hit   = (hw >= 0);
    e.way   = e.hit ? hw : vic;
    e.mesi  = e.hit ? m_mesi[s][hw] : 0;
    e.vtag  = e.hit ? 0 : m_tag[s][vic];
    e.vmesi = e.hit ? 0 : m_mesi[s][vic];
    case (op)
      0: if (e.hit) model_touch(s, hw);
      1: if (e.hit) begin m_mesi[s][hw] = 3; model_touch(s, hw); end
      2: begin
        if (e.hit) begin
          m_mesi[s][hw] = ms;
          model_touch(s, hw);
        end else begin
          m_tag[s][vic]  = tg;
          m_mesi[s][vic] = ms;
          model_touch(s, vic);
        end
      end
      default: if (e.hit) m_mesi[s][hw] = ms;
    endcase
  endtask

  // Presents one request for one accept edge and samples 1 time unit later.
  task automatic drive(input int op, input int s, input int tg, input int ms);
    req_valid = 1'b1;
    req_op    = 2'(op);
    req_index = IB'(s);
    req_tag   = TB'(tg);
    req_mesi  = 2'(ms);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic check_resp(input string nm, input exp_t e, input bit chk_mesi, input bit chk_vic);
    check({nm, ".valid"}, 32'(resp_valid), 32'd1);
    check({nm, ".hit"},   32'(resp_hit),   32'(e.hit));
    if (chk_mesi) check({nm, ".mesi"}, 32'(resp_mesi), 32'(e.mesi));
    if (chk_vic) begin
      check({nm, ".way"},   32'(resp_way),         32'(e.way));
      check({nm, ".vtag"},  32'(resp_victim_tag),  32'(e.vtag));
      check({nm, ".vmesi"}, 32'(resp_victim_mesi), 32'(e.vmesi));
    end
  endtask

  task automatic wait_init(input string nm);
    int n;
    bit saw;
    n   = 0;
    saw = 1'b0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (resp_valid) saw = 1'b1;
      if (req_ready) break;
    end
    req_valid = 1'b0;
    check({nm, ".cycles"},    32'(n),         32'd8);
    check({nm, ".init_done"}, 32'(init_done), 32'd1);
    check({nm, ".no_resp"},   32'(saw),       32'd0);
  endtask

  function automatic vec_t mk(input int op, input int s, input int tg, input int ms,
                              input bit hit, input int way, input int rm, input int vt, input int vm);
    vec_t v;
    v.op = op; v.idx = s; v.tag = tg; v.mesi = ms;
    v.e.hit = hit; v.e.way = way; v.e.mesi = rm; v.e.vtag = vt; v.e.vmesi = vm;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // op: 0 READ, 1 WRITE, 2 FILL, 3 SNOOP; mesi: 0 I, 1 S, 2 E, 3 M
    vecs[0]  = mk(0, 2, 8'h00, 0,  0, 0, 0, 8'h00, 0);
    vecs[1]  = mk(2, 5, 8'h11, 2,  0, 0, 0, 8'h00, 0);
    vecs[2]  = mk(2, 5, 8'h12, 2,  0, 1, 0, 8'h00, 0);
    vecs[3]  = mk(2, 5, 8'h13, 2,  0, 2, 0, 8'h00, 0);
    vecs[4]  = mk(2, 5, 8'h14, 2,  0, 3, 0, 8'h00, 0);
    vecs[5]  = mk(2, 5, 8'h15, 2,  0, 0, 0, 8'h11, 2);
    vecs[6]  = mk(0, 5, 8'h12, 0,  1, 1, 2, 8'h00, 0);
    vecs[7]  = mk(2, 5, 8'h16, 2,  0, 2, 0, 8'h13, 2);
    vecs[8]  = mk(2, 1, 8'h20, 1,  0, 0, 0, 8'h00, 0);
    vecs[9]  = mk(1, 1, 8'h20, 0,  1, 0, 1, 8'h00, 0);
    vecs[10] = mk(0, 1, 8'h20, 0,  1, 0, 3, 8'h00, 0);
    vecs[11] = mk(1, 1, 8'h99, 0,  0, 1, 0, 8'h00, 0);
    vecs[12] = mk(3, 1, 8'h20, 0,  1, 0, 3, 8'h00, 0);
    vecs[13] = mk(0, 1, 8'h20, 0,  0, 0, 0, 8'h20, 0);
    // Snoop the LRU line of set 5; if it were touched the next victim would move.
    vecs[14] = mk(3, 5, 8'h14, 1,  1, 3, 2, 8'h00, 0);
    vecs[15] = mk(0, 5, 8'h77, 0,  0, 3, 0, 8'h14, 1);

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_index = '0;
    req_tag   = '0;
    req_mesi  = '0;
    model_reset();

    #1;
    check("rst.req_ready",  32'(req_ready),        32'd0);
    check("rst.init_done",  32'(init_done),        32'd0);
    check("rst.resp_valid", 32'(resp_valid),       32'd0);
    check("rst.resp_hit",   32'(resp_hit),         32'd0);
    check("rst.resp_way",   32'(resp_way),         32'd0);
    check("rst.resp_mesi",  32'(resp_mesi),        32'd0);
    check("rst.vtag",       32'(resp_victim_tag),  32'd0);
    check("rst.vmesi",      32'(resp_victim_mesi), 32'd0);

    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    wait_init("init");

    // Directed vectors, issued back-to-back.
    for (int i = 0; i < 16; i++) begin
      exp_t dummy;
      model_step(vecs[i].op, vecs[i].idx, vecs[i].tag, vecs[i].mesi, dummy);
      drive(vecs[i].op, vecs[i].idx, vecs[i].tag, vecs[i].mesi);
      check_resp($sformatf("vec%0d", i), vecs[i].e, vecs[i].e.hit, 1'b1);
    end

    // Idle cycle: pulse drops, response fields hold.
    @(posedge clk);
    #1;
    check("idle.valid", 32'(resp_valid),      32'd0);
    check("idle.way",   32'(resp_way),        32'd3);
    check("idle.vtag",  32'(resp_victim_tag), 32'h14);

    // Randomized traffic over a small tag pool so hits and evictions mix.
    for (int i = 0; i < 300; i++) begin
      int   op;
      int   s;
      int   tg;
      int   ms;
      exp_t e;
      op = int'($urandom_range(0, 3));
      s  = int'($urandom_range(0, NS - 1));
      tg = 8'h40 + int'($urandom_range(0, 5));
      ms = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
        check($sformatf("rnd%0d.idle", i), 32'(resp_valid), 32'd0);
      end
      model_step(op, s, tg, ms, e);
      drive(op, s, tg, ms);
      check_resp($sformatf("rnd%0d", i), e, e.hit, (op != 3) || e.hit);
    end

    // Reset in the middle of back-to-back traffic.
    req_valid = 1'b1;
    req_op    = 2'd0;
    req_index = IB'(5);
    req_tag   = TB'(8'h12);
    req_mesi  = 2'd0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("mid.pre_valid", 32'(resp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid.resp_valid", 32'(resp_valid), 32'd0);
    check("mid.init_done",  32'(init_done),  32'd0);
    check("mid.req_ready",  32'(req_ready),  32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    wait_init("reinit");

    begin
      exp_t e;
      model_step(0, 5, 8'h12, 0, e);
      drive(0, 5, 8'h12, 0);
      check_resp("post_reset", e, 1'b0, 1'b1);
      check("post_reset.miss", 32'(resp_hit), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
